// File: rtl/bcd_pkg.sv
// bcd_pkg: shared constants and FSM state encoding for the BCD-to-binary
// converter (bcd_to_binary_seq and bcd_nibble_corrector).
//   BCD_DIGIT_W      bits per BCD digit
//   BCD_CORR_THRESH  nibble value at or above which a correction applies
//   BCD_CORR_SUB     amount subtracted from a nibble needing correction
//   state_t          ST_IDLE / ST_CONV / ST_DONE
package bcd_pkg;

  localparam int         BCD_DIGIT_W     = 4;
  localparam logic [3:0] BCD_CORR_THRESH = 4'd8;
  localparam logic [3:0] BCD_CORR_SUB    = 4'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_nibble_corrector.sv
// bcd_nibble_corrector: combinational per-digit correction step of the
// reverse double-dabble algorithm: (x >= 8) ? x - 3 : x, in 4-bit arithmetic.
// Ports:
//   nibble     in   4  digit value after the right shift
//   corrected  out  4  digit value after correction
module bcd_nibble_corrector
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] nibble,
  output logic [BCD_DIGIT_W-1:0] corrected
);

  assign corrected = (nibble >= BCD_CORR_THRESH) ? (nibble - BCD_CORR_SUB) : nibble;

endmodule

// File: rtl/bcd_to_binary_seq.sv
// bcd_to_binary_seq: multi-cycle BCD-to-binary converter (reverse double
// dabble), one shift/correct iteration per clock, start/busy/done handshake.
// Optional feature macro: BCD_RANGE_CHECK_EN -- when defined, a start with
// any digit > 9 goes straight to DONE with error_out=1 and binary_out=0;
// when undefined, no check is made and error_out is tied 0.
// Ports:
//   clk_in      in   1         clock, rising edge
//   rst_n_in    in   1         synchronous active-low reset
//   start_in    in   1         conversion request, sampled only in IDLE
//   bcd_in      in   4*DIGITS  packed digits, [3:0] = units
//   busy_out    out  1         high in CONV and DONE
//   done_out    out  1         one-cycle pulse, binary_out valid from here
//   binary_out  out  BIN_W     result, held until the next DONE
//   error_out   out  1         invalid-digit flag (range-check build only)
module bcd_to_binary_seq
  import bcd_pkg::*;
#(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
) (
  input  logic                            clk_in,
  input  logic                            rst_n_in,
  input  logic                            start_in,
  input  logic [BCD_DIGIT_W*DIGITS-1:0]   bcd_in,
  output logic                            busy_out,
  output logic                            done_out,
  output logic [BIN_W-1:0]                binary_out,
  output logic                            error_out
);

  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BIN_W);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t state, state_nxt;

  logic [BCD_W-1:0] bcd_sh;
  logic [BCD_W-1:0] bcd_shr;
  logic [BCD_W-1:0] bcd_corr;
  // Only bits [BIN_W-1:1] of the binary half of the working register are
  // kept: bit 0 is always shifted out before it could reach the result.
  logic [BIN_W-2:0] bin_hi;
  logic [BIN_W-1:0] bin_shr;
  logic [CNT_W-1:0] cnt;
  logic             bad_digit;
  logic             last_iter;

  // Step 1: right shift of {bcd_sh, bin_sh}; the units LSB enters the binary MSB.
  assign bcd_shr   = bcd_sh >> 1;
  assign bin_shr   = {bcd_sh[0], bin_hi};
  assign last_iter = (cnt == CNT_ONE);

  // Step 2: independent per-digit correction, no borrow between nibbles.
  for (genvar g = 0; g < DIGITS; g++) begin : g_corr
    bcd_nibble_corrector u_corr (
      .nibble    (bcd_shr [g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .corrected (bcd_corr[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

`ifdef BCD_RANGE_CHECK_EN
  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_in[i*BCD_DIGIT_W +: BCD_DIGIT_W] > 4'd9) bad_digit = 1'b1;
    end
  end
`else
  assign bad_digit = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) state <= ST_IDLE;
    else           state <= state_nxt;
  end

  // FSM next state / outputs
  always_comb begin
    state_nxt = state;
    busy_out  = 1'b0;
    unique case (state)
      ST_IDLE: if (start_in) state_nxt = bad_digit ? ST_DONE : ST_CONV;
      ST_CONV: begin
        busy_out = 1'b1;
        if (last_iter) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        busy_out  = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: working register, counter, and registered result/done.
  // done_out and binary_out are loaded on the edge that enters DONE so
  // both are valid throughout the DONE cycle.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      bcd_sh     <= '0;
      bin_hi     <= '0;
      cnt        <= '0;
      binary_out <= '0;
      done_out   <= 1'b0;
    end else begin
      done_out <= 1'b0;
      unique case (state)
        ST_IDLE: if (start_in) begin
          bcd_sh <= bcd_in;
          bin_hi <= '0;
          cnt    <= CNT_LOAD;
          if (bad_digit) begin
            binary_out <= '0;
            done_out   <= 1'b1;
          end
        end
        ST_CONV: begin
          bcd_sh <= bcd_corr;
          bin_hi <= bin_shr[BIN_W-1:1];
          cnt    <= cnt - CNT_ONE;
          if (last_iter) begin
            binary_out <= bin_shr;
            done_out   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef BCD_RANGE_CHECK_EN
  // Error flag follows the most recently accepted start.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in)                          error_out <= 1'b0;
    else if (state == ST_IDLE && start_in)  error_out <= bad_digit;
  end
`else
  assign error_out = 1'b0;
`endif

endmodule
